// File: rtl/ifu_flush_rsp.sv
// Fetch-side responder for the commit flush request/ack channel.
// Drains outstanding fetches, acks the flush and presents the registered redirect PC.
module ifu_flush_rsp #(
  parameter int PC_SIZE    = 32,
  parameter int OUTS_DEPTH = 2,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_req,
  input  logic [PC_SIZE-1:0] flush_add_op1,
  input  logic [PC_SIZE-1:0] flush_add_op2,
  output logic               flush_ack,
  input  logic               ifu_req_hsked,
  input  logic               ifu_rsp_hsked,
  output logic               fetch_block,
  output logic               rsp_discard,
  output logic               redirect_vld,
  output logic [PC_SIZE-1:0] redirect_pc,
  output logic [CNT_W-1:0]   outs_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(OUTS_DEPTH);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   outs_cnt_q, outs_cnt_d;
  logic               redirect_vld_q, redirect_vld_d;
  logic [PC_SIZE-1:0] redirect_pc_q, redirect_pc_d;
  logic               drain_done;
  logic               ack_int;

  // The last outstanding response returning this cycle counts as drained.
  assign drain_done = (outs_cnt_q == '0) |
                      ((outs_cnt_q == CntOne) & ifu_rsp_hsked & ~ifu_req_hsked);

  // Outputs are masked while reset is asserted so commit never sees a spurious ack.
  assign ack_int     = flush_req & drain_done;
  assign flush_ack   = ack_int & rst_n;
  assign rsp_discard = ((state_q == DRAIN) | (flush_req & ifu_rsp_hsked)) & rst_n;
  assign fetch_block = flush_req | (state_q == DRAIN) | (outs_cnt_q == CntMax);

  always_comb begin
    outs_cnt_d = outs_cnt_q;
    if (ifu_req_hsked & ~ifu_rsp_hsked & (outs_cnt_q != CntMax)) begin
      outs_cnt_d = outs_cnt_q + CntOne;
    end else if (ifu_rsp_hsked & ~ifu_req_hsked & (outs_cnt_q != '0)) begin
      outs_cnt_d = outs_cnt_q - CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req & ~drain_done) state_d = DRAIN;
      DRAIN:   if (~flush_req | drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Redirect target is captured only on the ack handshake; carry out is dropped.
  always_comb begin
    redirect_vld_d = ack_int;
    redirect_pc_d  = redirect_pc_q;
    if (ack_int) begin
      redirect_pc_d = flush_add_op1 + flush_add_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      outs_cnt_q     <= '0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      state_q        <= state_d;
      outs_cnt_q     <= outs_cnt_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign redirect_vld = redirect_vld_q;
  assign redirect_pc  = redirect_pc_q;
  assign outs_cnt     = outs_cnt_q;

endmodule

// File: tb/tb_ifu_flush_rsp.sv
// Directed self-checking bench for ifu_flush_rsp: idle ack, drain, withdrawal,
// address wrap, back-to-back flushes, counter limits and asynchronous reset.
module tb_ifu_flush_rsp;

  localparam int PC_SIZE    = 32;
  localparam int OUTS_DEPTH = 2;
  localparam int CNT_W      = 3;

  logic               clk;
  logic               rst_n;
  logic               flush_req;
  logic [PC_SIZE-1:0] flush_add_op1;
  logic [PC_SIZE-1:0] flush_add_op2;
  logic               flush_ack;
  logic               ifu_req_hsked;
  logic               ifu_rsp_hsked;
  logic               fetch_block;
  logic               rsp_discard;
  logic               redirect_vld;
  logic [PC_SIZE-1:0] redirect_pc;
  logic [CNT_W-1:0]   outs_cnt;

  int n_checks;
  int n_fail;

  ifu_flush_rsp #(
    .PC_SIZE   (PC_SIZE),
    .OUTS_DEPTH(OUTS_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_req    (flush_req),
    .flush_add_op1(flush_add_op1),
    .flush_add_op2(flush_add_op2),
    .flush_ack    (flush_ack),
    .ifu_req_hsked(ifu_req_hsked),
    .ifu_rsp_hsked(ifu_rsp_hsked),
    .fetch_block  (fetch_block),
    .rsp_discard  (rsp_discard),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .outs_cnt     (outs_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush_req = 1'b1;
    flush_add_op1 = 32'h0;
    flush_add_op2 = 32'h0;
    ifu_req_hsked = 1'b0;
    ifu_rsp_hsked = 1'b1;
    #3;
    n_checks++; if (outs_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d expected 0", outs_cnt); end
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vld: got %b expected 0", redirect_vld); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected 0", redirect_pc); end
    n_checks++; if (flush_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected 0", flush_ack); end
    n_checks++; if (rsp_discard !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_discard: got %b expected 0", rsp_discard); end
    tick();
    tick();
    flush_req = 1'b0;
    ifu_rsp_hsked = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_ack();
    flush_req = 1'b1;
    flush_add_op1 = 32'h8000_0100;
    flush_add_op2 = 32'h4;
    #1;
    n_checks++; if (flush_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_ack: got %b expected 1", flush_ack); end
    n_checks++; if (fetch_block !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_block: got %b expected 1", fetch_block); end
    tick();
    flush_req = 1'b0;
    #1;
    n_checks++; if (redirect_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_vld: got %b expected 1", redirect_vld); end
    n_checks++; if (redirect_pc !== 32'h8000_0104) begin n_fail++; $display("[TB] FAIL idle_pc: got %h expected 80000104", redirect_pc); end
    tick();
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_vld_pulse: got %b expected 0", redirect_vld); end
    n_checks++; if (redirect_pc !== 32'h8000_0104) begin n_fail++; $display("[TB] FAIL idle_pc_hold: got %h expected 80000104", redirect_pc); end
  endtask

  task automatic test_drain();
    ifu_req_hsked = 1'b1;
    tick();
    tick();
    ifu_req_hsked = 1'b0;
    #1;
    n_checks++; if (outs_cnt !== 3'd2) begin n_fail++; $display("[TB] FAIL drain_cnt2: got %0d expected 2", outs_cnt); end
    flush_req = 1'b1;
    flush_add_op1 = 32'h1000;
    flush_add_op2 = 32'h20;
    #1;
    n_checks++; if (flush_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_early_ack: got %b expected 0", flush_ack); end
    tick();
    n_checks++; if (rsp_discard !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_discard: got %b expected 1", rsp_discard); end
    n_checks++; if (fetch_block !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_block: got %b expected 1", fetch_block); end
    ifu_rsp_hsked = 1'b1;
    #1;
    n_checks++; if (flush_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_ack_cnt2: got %b expected 0", flush_ack); end
    tick();
    n_checks++; if (outs_cnt !== 3'd1) begin n_fail++; $display("[TB] FAIL drain_cnt1: got %0d expected 1", outs_cnt); end
    n_checks++; if (flush_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_ack: got %b expected 1", flush_ack); end
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_vld_early: got %b expected 0", redirect_vld); end
    tick();
    flush_req = 1'b0;
    ifu_rsp_hsked = 1'b0;
    #1;
    n_checks++; if (redirect_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_vld: got %b expected 1", redirect_vld); end
    n_checks++; if (redirect_pc !== 32'h1020) begin n_fail++; $display("[TB] FAIL drain_pc: got %h expected 00001020", redirect_pc); end
    n_checks++; if (outs_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL drain_cnt0: got %0d expected 0", outs_cnt); end
    n_checks++; if (rsp_discard !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_idle_discard: got %b expected 0", rsp_discard); end
    n_checks++; if (fetch_block !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_idle_block: got %b expected 0", fetch_block); end
    tick();
  endtask

  task automatic test_withdraw();
    ifu_req_hsked = 1'b1;
    tick();
    ifu_req_hsked = 1'b0;
    flush_req = 1'b1;
    flush_add_op1 = 32'h5555_0000;
    flush_add_op2 = 32'h10;
    #1;
    n_checks++; if (flush_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_ack0: got %b expected 0", flush_ack); end
    tick();
    tick();
    flush_req = 1'b0;
    #1;
    n_checks++; if (flush_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_ack1: got %b expected 0", flush_ack); end
    n_checks++; if (rsp_discard !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_discard: got %b expected 1", rsp_discard); end
    tick();
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_vld: got %b expected 0", redirect_vld); end
    n_checks++; if (fetch_block !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_block: got %b expected 0", fetch_block); end
    n_checks++; if (rsp_discard !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_idle: got %b expected 0", rsp_discard); end
    n_checks++; if (redirect_pc !== 32'h1020) begin n_fail++; $display("[TB] FAIL wd_pc_hold: got %h expected 00001020", redirect_pc); end
    n_checks++; if (outs_cnt !== 3'd1) begin n_fail++; $display("[TB] FAIL wd_cnt: got %0d expected 1", outs_cnt); end
    ifu_rsp_hsked = 1'b1;
    tick();
    ifu_rsp_hsked = 1'b0;
    #1;
  endtask

  task automatic test_wrap_back_to_back();
    flush_req = 1'b1;
    flush_add_op1 = 32'hFFFF_FFFE;
    flush_add_op2 = 32'h4;
    #1;
    n_checks++; if (flush_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_ack: got %b expected 1", flush_ack); end
    tick();
    n_checks++; if (redirect_pc !== 32'h0000_0002) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected 00000002", redirect_pc); end
    n_checks++; if (redirect_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_vld: got %b expected 1", redirect_vld); end
    flush_add_op1 = 32'h2000_0040;
    flush_add_op2 = 32'h0;
    #1;
    n_checks++; if (flush_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ack: got %b expected 1", flush_ack); end
    tick();
    flush_req = 1'b0;
    #1;
    n_checks++; if (redirect_pc !== 32'h2000_0040) begin n_fail++; $display("[TB] FAIL b2b_pc: got %h expected 20000040", redirect_pc); end
    n_checks++; if (redirect_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_vld: got %b expected 1", redirect_vld); end
    tick();
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_vld_end: got %b expected 0", redirect_vld); end
  endtask

  task automatic test_counter_limits();
    ifu_req_hsked = 1'b1;
    tick();
    n_checks++; if (fetch_block !== 1'b0) begin n_fail++; $display("[TB] FAIL cnt_block1: got %b expected 0", fetch_block); end
    tick();
    n_checks++; if (outs_cnt !== 3'd2) begin n_fail++; $display("[TB] FAIL cnt_full: got %0d expected 2", outs_cnt); end
    n_checks++; if (fetch_block !== 1'b1) begin n_fail++; $display("[TB] FAIL cnt_block_full: got %b expected 1", fetch_block); end
    tick();
    n_checks++; if (outs_cnt !== 3'd2) begin n_fail++; $display("[TB] FAIL cnt_sat: got %0d expected 2", outs_cnt); end
    ifu_rsp_hsked = 1'b1;
    tick();
    n_checks++; if (outs_cnt !== 3'd2) begin n_fail++; $display("[TB] FAIL cnt_hold: got %0d expected 2", outs_cnt); end
    ifu_req_hsked = 1'b0;
    n_checks++; if (rsp_discard !== 1'b0) begin n_fail++; $display("[TB] FAIL cnt_discard: got %b expected 0", rsp_discard); end
    tick();
    n_checks++; if (outs_cnt !== 3'd1) begin n_fail++; $display("[TB] FAIL cnt_dec: got %0d expected 1", outs_cnt); end
    tick();
    tick();
    n_checks++; if (outs_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL cnt_underflow: got %0d expected 0", outs_cnt); end
    ifu_rsp_hsked = 1'b0;
    #1;
    n_checks++; if (fetch_block !== 1'b0) begin n_fail++; $display("[TB] FAIL cnt_block0: got %b expected 0", fetch_block); end
  endtask

  task automatic test_reset_mid_drain();
    ifu_req_hsked = 1'b1;
    tick();
    tick();
    ifu_req_hsked = 1'b0;
    flush_req = 1'b1;
    flush_add_op1 = 32'h3000;
    flush_add_op2 = 32'h8;
    tick();
    n_checks++; if (rsp_discard !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_drain: got %b expected 1", rsp_discard); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (outs_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0d expected 0", outs_cnt); end
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_vld: got %b expected 0", redirect_vld); end
    n_checks++; if (flush_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ack: got %b expected 0", flush_ack); end
    n_checks++; if (rsp_discard !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_discard: got %b expected 0", rsp_discard); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_pc: got %h expected 0", redirect_pc); end
    flush_req = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++; if (fetch_block !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_idle_block: got %b expected 0", fetch_block); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_idle_ack();
    test_drain();
    test_withdraw();
    test_wrap_back_to_back();
    test_counter_limits();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
